fp_add_normalize: RTL and testbench



---
 rtl/fp_add_normalize.sv | 218 +++++++++++++++++++++
 tb/tb_fp_add_normalize.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// FP32 adder back end: mantissa add/subtract, normalize, round-to-nearest-even, pack.
// Build option FPNORM_LEADZERO_EN: single-cycle leading-zero normalization instead of one shift per cycle.
module fp_add_normalize #(
    parameter int MANT_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bypass,
    input  logic [31:0] in_bypass_result,
    input  logic        in_sign_a,
    input  logic        in_sign_b,
    input  logic [7:0]  in_exponent,
    input  logic [31:0] in_mantissa_a,
    input  logic [31:0] in_mantissa_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow
);

    localparam int GRD_W  = 8;
    localparam int FRAC_W = MANT_W - 1 - GRD_W;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [31:0]       result_q;
    logic              overflow_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [MANT_W-1:0] mant_a_q;
    logic [MANT_W-1:0] mant_b_q;
    logic              sign_q;
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W:0]    exp_q;
    logic              zero_q;

    logic [MANT_W:0]   sum_d;
    logic              sum_sign_d;
    logic [MANT_W-1:0] add_mant_d;
    logic [EXP_W:0]    add_exp_d;
    logic              add_zero_d;

    logic [MANT_W-1:0] norm_mant_d;
    logic [EXP_W:0]    norm_exp_d;
    logic              norm_done_d;

    logic              rnd_inc_d;
    logic [FRAC_W+1:0] rnd_sum_d;
    logic [FRAC_W:0]   rnd_sig_d;
    logic [EXP_W:0]    rnd_exp_d;
    logic              rnd_ovf_d;
    logic [31:0]       rnd_result_d;

    // Magnitude add/subtract; a carry out is folded back with the dropped bit kept as sticky.
    always_comb begin
        sum_d      = '0;
        sum_sign_d = sign_a_q;
        if (sign_a_q == sign_b_q) begin
            sum_d = {1'b0, mant_a_q} + {1'b0, mant_b_q};
        end else if (mant_a_q >= mant_b_q) begin
            sum_d = {1'b0, mant_a_q} - {1'b0, mant_b_q};
        end else begin
            sum_d      = {1'b0, mant_b_q} - {1'b0, mant_a_q};
            sum_sign_d = sign_b_q;
        end
        add_zero_d = (sum_d == '0);
        if (sum_d[MANT_W]) begin
            add_mant_d = {sum_d[MANT_W:2], sum_d[1] | sum_d[0]};
            add_exp_d  = exp_q + EXP_ONE;
        end else begin
            add_mant_d = sum_d[MANT_W-1:0];
            add_exp_d  = exp_q;
        end
    end

`ifdef FPNORM_LEADZERO_EN
    function automatic logic [EXP_W:0] lead_zeros(input logic [MANT_W-1:0] m);
        logic [EXP_W:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < MANT_W; i++) begin
            if (!hit && !m[MANT_W-1-i]) n = n + EXP_ONE;
            else                        hit = 1'b1;
        end
        return n;
    endfunction

    logic [EXP_W:0] lz_d;
    logic [EXP_W:0] norm_shift_d;

    // Shift is clamped so the exponent never drops below 1 (subnormal floor).
    always_comb begin
        lz_d         = lead_zeros(mant_q);
        norm_shift_d = (lz_d < exp_q - EXP_ONE) ? lz_d : (exp_q - EXP_ONE);
        norm_mant_d  = mant_q << norm_shift_d;
        norm_exp_d   = exp_q - norm_shift_d;
        norm_done_d  = 1'b1;
    end
`else
    always_comb begin
        norm_mant_d = {mant_q[MANT_W-2:0], 1'b0};
        norm_exp_d  = exp_q - EXP_ONE;
        norm_done_d = norm_mant_d[MANT_W-1] || (norm_exp_d == EXP_ONE);
    end
`endif

    // Round to nearest even on bits [GRD_W-1:0]; a hidden-bit carry renormalizes by one.
    always_comb begin
        rnd_inc_d = mant_q[GRD_W-1] & ((|mant_q[GRD_W-2:0]) | mant_q[GRD_W]);
        rnd_sum_d = {1'b0, mant_q[MANT_W-1:GRD_W]} + {{(FRAC_W+1){1'b0}}, rnd_inc_d};
        if (rnd_sum_d[FRAC_W+1]) begin
            rnd_sig_d = rnd_sum_d[FRAC_W+1:1];
            rnd_exp_d = exp_q + EXP_ONE;
        end else begin
            rnd_sig_d = rnd_sum_d[FRAC_W:0];
            rnd_exp_d = exp_q;
        end
        rnd_ovf_d = !zero_q && (rnd_exp_d >= EXP_MAX);
        if (zero_q) begin
            rnd_result_d = '0;
        end else if (rnd_ovf_d) begin
            rnd_result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            rnd_result_d = {sign_q,
                            rnd_sig_d[FRAC_W] ? rnd_exp_d[EXP_W-1:0] : {EXP_W{1'b0}},
                            rnd_sig_d[FRAC_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            sign_q      <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (in_bypass) begin
                            result_q    <= in_bypass_result;
                            overflow_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            sign_a_q <= in_sign_a;
                            sign_b_q <= in_sign_b;
                            mant_a_q <= in_mantissa_a;
                            mant_b_q <= in_mantissa_b;
                            exp_q    <= {1'b0, in_exponent};
                            state_q  <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    sign_q <= sum_sign_d;
                    mant_q <= add_mant_d;
                    exp_q  <= add_exp_d;
                    zero_q <= add_zero_d;
                    if (add_zero_d || add_mant_d[MANT_W-1] || (add_exp_d <= EXP_ONE))
                        state_q <= S_ROUND;
                    else
                        state_q <= S_NORM;
                end
                S_NORM: begin
                    mant_q <= norm_mant_d;
                    exp_q  <= norm_exp_d;
                    if (norm_done_d) state_q <= S_ROUND;
                end
                S_ROUND: begin
                    result_q    <= rnd_result_d;
                    overflow_q  <= rnd_ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = result_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Randomized bench for fp_add_normalize against an exact-integer rounding model.
module tb_fp_add_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_bypass;
    logic [31:0] in_bypass_result;
    logic        in_sign_a;
    logic        in_sign_b;
    logic [7:0]  in_exponent;
    logic [31:0] in_mantissa_a;
    logic [31:0] in_mantissa_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;

    int n_total = 0;
    int n_pass  = 0;

    fp_add_normalize #(.MANT_W(32), .EXP_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_bypass        (in_bypass),
        .in_bypass_result (in_bypass_result),
        .in_sign_a        (in_sign_a),
        .in_sign_b        (in_sign_b),
        .in_exponent      (in_exponent),
        .in_mantissa_a    (in_mantissa_a),
        .in_mantissa_b    (in_mantissa_b),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_overflow     (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp_v);
    endtask

    // Exact signed sum, then RNE to 24 significant bits at the position the exponent allows.
    function automatic void ref_add(input logic sa, input logic sb, input int e,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o, output int lat);
        longint      s;
        logic [63:0] mag, q, rem, half;
        logic        sgn;
        int          p, ee, l, shifts;
        s = (sa ? -longint'(a) : longint'(a)) + (sb ? -longint'(b) : longint'(b));
        o = 1'b0;
        if (s == 0) begin
            r = 32'h0; lat = 3;
            return;
        end
        sgn = (s < 0);
        mag = sgn ? 64'(-s) : 64'(s);
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p == 32) ee = e + 1;
        else ee = (e + p - 31 > 1) ? e + p - 31 : 1;
        shifts = (ee < e) ? e - ee : 0;
`ifdef FPNORM_LEADZERO_EN
        lat = (shifts > 0) ? 4 : 3;
`else
        lat = 3 + shifts;
`endif
        l = 8 + ee - e;
        if (l > 0) begin
            q    = mag >> l;
            rem  = mag & ((64'd1 << l) - 64'd1);
            half = 64'd1 << (l - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end else begin
            q = mag << (-l);
        end
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) begin
            r = {sgn, 8'hFF, 23'h0};
            o = 1'b1;
        end else begin
            r = {sgn, (q >= (64'd1 << 23)) ? 8'(ee) : 8'h00, q[22:0]};
        end
    endfunction

    task automatic run_op(input logic byp, input logic [31:0] bres, input logic sa, input logic sb,
                          input logic [7:0] e, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat,
                          input int hold);
        int cyc;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_bypass = byp; in_bypass_result = bres;
        in_sign_a = sa; in_sign_b = sb; in_exponent = e;
        in_mantissa_a = a; in_mantissa_b = b;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("result", out_result, exp_res);
        check("overflow", 32'(out_overflow), 32'(exp_ovf));
        check("latency", 32'(cyc), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, exp_res);
            check("hold_overflow", 32'(out_overflow), 32'(exp_ovf));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, r, t;
        logic        sa, sb, o;
        int          e, lat, kind, saw;

        reset = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; in_bypass_result = '0;
        in_sign_a = 1'b0; in_sign_b = 1'b0; in_exponent = '0;
        in_mantissa_a = '0; in_mantissa_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'h0);
        check("rst_overflow", 32'(out_overflow), 32'd0);

        run_op(0, 0, 0, 0, 127, 32'h80000000, 32'h80000000, 32'h40000000, 0, 3, 0);
        run_op(0, 0, 0, 1, 127, 32'hC0000000, 32'h80000000, 32'h3F000000, 0, 4, 0);
        run_op(0, 0, 0, 1, 127, 32'h80000000, 32'h80000000, 32'h00000000, 0, 3, 0);
        run_op(0, 0, 0, 0, 127, 32'h80000000, 32'h00000180, 32'h3F800002, 0, 3, 0);
        run_op(0, 0, 0, 0, 127, 32'h80000000, 32'h00000080, 32'h3F800000, 0, 3, 0);
        run_op(0, 0, 0, 0, 254, 32'hFFFFFF00, 32'hFFFFFF00, 32'h7F800000, 1, 3, 2);
        run_op(1, 32'h7FC00000, 0, 0, 0, 0, 0, 32'h7FC00000, 0, 1, 5);
        run_op(0, 0, 1, 0, 127, 32'h80000000, 32'hC0000000, 32'h3F000000, 0, 4, 5);

        // Reset while normalizing a massive cancellation.
        in_bypass = 1'b0; in_sign_a = 1'b0; in_sign_b = 1'b1; in_exponent = 8'd127;
        in_mantissa_a = 32'h80000000; in_mantissa_b = 32'h7FFFFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", out_result, 32'h0);
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1;
        end
        check("midrst_no_emit", 32'(saw), 32'd0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            sa = 1'($urandom); sb = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       e = $urandom_range(1, 8);
                1:       e = $urandom_range(248, 254);
                default: e = $urandom_range(1, 254);
            endcase
            a = {1'b1, 31'($urandom)};
            case (kind)
                0: b = {1'b1, 31'($urandom)} >> $urandom_range(0, 31);
                1: b = a ^ (32'($urandom) >> $urandom_range(8, 31));
                2: begin a = 32'($urandom); b = 32'($urandom); end
                3: b = a;
                4: b = {1'b1, 31'($urandom)} >> $urandom_range(20, 31);
                default: b = {1'b1, 31'($urandom)} >> $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
            if (kind == 9) begin
                t = 32'($urandom);
                run_op(1, t, sa, sb, 8'(e), a, b, t, 0, 1, $urandom_range(0, 2));
            end else begin
                ref_add(sa, sb, e, a, b, r, o, lat);
                run_op(0, 0, sa, sb, 8'(e), a, b, r, o, lat, $urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
